video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter: HW, 10, column counter width in bits.
REQ-002 Parameter: VW, 10, row counter width in bits.
REQ-003 Parameter: H_TOTAL, 454, clocks-enabled per line; columns run 0..H_TOTAL-1.
REQ-004 Parameter: V_TOTAL_NTSC, 263, lines per NTSC frame.
REQ-005 Parameter: V_TOTAL_PAL, 313, lines per PAL frame.
REQ-006 Parameter: HSYNC_END 66, HBLANK_START 440, HBLANK_END 68, BORDER_START 413, BORDER_END 93, LRC_COL 412, PRST_COL 418, VBE_COL 12: column decode points.
REQ-007 Parameter: VSYNC_END 3, VBLANK_END 16, VBLANK_START_NTSC 258, VBLANK_START_PAL 308: row decode points.
REQ-008 Ports, one per line: name, direction, width, meaning.
REQ-009 clk  in  1  sole clock; all state is on its rising edge.
REQ-010 reset_n  in  1  asynchronous, active-low reset.
REQ-011 ce  in  1  pixel-clock enable; the counters advance only when high.
REQ-012 mode_req  in  1  requested standard: 0 = NTSC, 1 = PAL.
REQ-013 hide_border  in  1  when high, hblank equals border.
REQ-014 load, load_row[VW], load_col[HW]  in  counter preload (BIOS-bypass start point).
REQ-015 row[VW], col[HW]  out  current position.
REQ-016 mode  out  1  active standard.
REQ-017 hsync, vsync, hblank, vblank, border  out  1  level timing signals.
REQ-018 lrc, prst, vbe, hbs, sof  out  1  single-clk event strobes.
REQ-019 frame_cnt  out  16  completed-frame counter.

Function
REQ-020 On ce, col increments; at col == H_TOTAL-1 col goes to 0 and row increments.
REQ-021 At the line wrap with row == vtotal(mode)-1, row goes to 0 (frame wrap); frame_cnt increments modulo 2^16; sof pulses.
REQ-022 mode samples mode_req only at frame wrap; a mode_req change mid-frame has no effect until the next frame wrap.
REQ-023 load has priority over ce and sets row/col to load_row/load_col; a value at or above its total loads 0; mode and frame_cnt are unchanged; no strobe fires that clk.
REQ-024 All level outputs are registered and decoded from the next counter value, so they align with row/col with zero latency.
REQ-025 Level outputs: hsync = col < HSYNC_END; border = col >= BORDER_START or col < BORDER_END; hblank = col >= HBLANK_START or col < HBLANK_END, unless hide_border is high.
REQ-026 Level outputs: vsync = row < VSYNC_END; vblank = row >= VBLANK_START(mode) or row < VBLANK_END.
REQ-027 Strobes assert for exactly one clk, in the cycle after a ce edge moves col to the target count: lrc at LRC_COL, prst at PRST_COL, hbs at HBLANK_START, vbe at row == VBLANK_END with VBE_COL; strobes never repeat while ce is low.
REQ-028 sof asserts for one clk when row/col first become 0/0 after a frame wrap.
REQ-029 If ce stays low, all state holds indefinitely.
REQ-030 The counter arithmetic is unsigned and truncated to HW/VW bits; the next-value comparison uses >= so an out-of-range state recovers within one line.

Reset
REQ-031 reset_n low asynchronously clears row, col and frame_cnt to 0, mode to 0 and all strobes to 0.
REQ-032 The level outputs reset to their decode at 0/0: hsync = 1, vsync = 1, vblank = 1, border = 1, hblank = 1.
REQ-033 Reset deassertion is synchronised externally; the first ce after release advances col to 1.

Structure
REQ-034 The shared package video_pkg holds the mode enum (MODE_NTSC, MODE_PAL) and the default timing constants.
REQ-035 One sub-module, video_strobe_gen, performs the one-clk compare-and-pulse for a single column/row point and is instantiated per strobe.

Verification
REQ-036 Reset, then ce continuous in NTSC -> col wraps after 453; frame wrap occurs after 454*263 ce; frame_cnt = 1; sof pulses once.
REQ-037 mode_req = 1 set at row 100 -> mode stays 0 until the frame wrap; the next frame lasts 313 lines; vblank starts at row 308.
REQ-038 ce asserted once every 4 clk -> lrc high for exactly 1 clk per line at col 412; hbs high for 1 clk at col 440.
REQ-039 load with row 38, col 255 while ce is high -> next row/col = 38/255 with no strobe; load_col 500 -> col = 0.
REQ-040 hide_border = 1 at col 80 -> hblank = 1; at col 93 -> hblank = 0.
REQ-041 reset_n pulsed low mid-line at row 120, col 300 -> outputs reach their reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and default timing constants for the video timing generator.
package video_pkg;

  typedef enum logic {
    MODE_NTSC = 1'b0,
    MODE_PAL  = 1'b1
  } mode_t;

  localparam int unsigned DEF_H_TOTAL           = 454;
  localparam int unsigned DEF_V_TOTAL_NTSC      = 263;
  localparam int unsigned DEF_V_TOTAL_PAL       = 313;
  localparam int unsigned DEF_HSYNC_END         = 66;
  localparam int unsigned DEF_HBLANK_START      = 440;
  localparam int unsigned DEF_HBLANK_END        = 68;
  localparam int unsigned DEF_BORDER_START      = 413;
  localparam int unsigned DEF_BORDER_END        = 93;
  localparam int unsigned DEF_LRC_COL           = 412;
  localparam int unsigned DEF_PRST_COL          = 418;
  localparam int unsigned DEF_VBE_COL           = 12;
  localparam int unsigned DEF_VSYNC_END         = 3;
  localparam int unsigned DEF_VBLANK_END        = 16;
  localparam int unsigned DEF_VBLANK_START_NTSC = 258;
  localparam int unsigned DEF_VBLANK_START_PAL  = 308;

endpackage

// File: rtl/video_strobe_gen.sv
// One-clk pulse when an advancing counter lands on a given column (and optionally row).
module video_strobe_gen
  import video_pkg::*;
#(
  parameter int unsigned HW      = 10,
  parameter int unsigned VW      = 10,
  parameter int unsigned COL     = 0,
  parameter int unsigned ROW     = 0,
  parameter bit          USE_ROW = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          adv,
  input  logic [HW-1:0] col_nxt,
  input  logic [VW-1:0] row_nxt,
  output logic          pulse
);

  logic hit;

  always_comb begin
    hit = adv && (col_nxt == HW'(COL)) && (!USE_ROW || (row_nxt == VW'(ROW)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pulse <= 1'b0;
    else          pulse <= hit;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster counters with NTSC/PAL frame lengths, registered level decodes and event strobes.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned HW                = 10,
  parameter int unsigned VW                = 10,
  parameter int unsigned H_TOTAL           = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL_NTSC      = DEF_V_TOTAL_NTSC,
  parameter int unsigned V_TOTAL_PAL       = DEF_V_TOTAL_PAL,
  parameter int unsigned HSYNC_END         = DEF_HSYNC_END,
  parameter int unsigned HBLANK_START      = DEF_HBLANK_START,
  parameter int unsigned HBLANK_END        = DEF_HBLANK_END,
  parameter int unsigned BORDER_START      = DEF_BORDER_START,
  parameter int unsigned BORDER_END        = DEF_BORDER_END,
  parameter int unsigned LRC_COL           = DEF_LRC_COL,
  parameter int unsigned PRST_COL          = DEF_PRST_COL,
  parameter int unsigned VBE_COL           = DEF_VBE_COL,
  parameter int unsigned VSYNC_END         = DEF_VSYNC_END,
  parameter int unsigned VBLANK_END        = DEF_VBLANK_END,
  parameter int unsigned VBLANK_START_NTSC = DEF_VBLANK_START_NTSC,
  parameter int unsigned VBLANK_START_PAL  = DEF_VBLANK_START_PAL
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          mode_req,
  input  logic          hide_border,
  input  logic          load,
  input  logic [VW-1:0] load_row,
  input  logic [HW-1:0] load_col,
  output logic [VW-1:0] row,
  output logic [HW-1:0] col,
  output logic          mode,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          border,
  output logic          lrc,
  output logic          prst,
  output logic          vbe,
  output logic          hbs,
  output logic          sof,
  output logic [15:0]   frame_cnt
);

  mode_t         mode_q, mode_d;
  logic [HW-1:0] col_d;
  logic [VW-1:0] row_d;
  logic [15:0]   fc_d;
  logic [VW-1:0] vtot;
  logic [VW-1:0] vbs_d;
  logic          adv;
  logic          hsync_d, vsync_d, hblank_d, vblank_d, border_d;

  assign mode = logic'(mode_q);

  // Out-of-range counters compare with >= so they wrap back within one line.
  always_comb begin
    col_d  = col;
    row_d  = row;
    mode_d = mode_q;
    fc_d   = frame_cnt;
    adv    = 1'b0;
    vtot   = (mode_q == MODE_PAL) ? VW'(V_TOTAL_PAL) : VW'(V_TOTAL_NTSC);
    if (load) begin
      col_d = (load_col >= HW'(H_TOTAL)) ? '0 : load_col;
      row_d = (load_row >= vtot) ? '0 : load_row;
    end else if (ce) begin
      adv = 1'b1;
      if (col >= HW'(H_TOTAL - 1)) begin
        col_d = '0;
        if (row >= vtot - VW'(1)) begin
          row_d  = '0;
          mode_d = mode_t'(mode_req);
          fc_d   = frame_cnt + 16'd1;
        end else begin
          row_d = row + VW'(1);
        end
      end else begin
        col_d = col + HW'(1);
      end
    end
  end

  // Levels are decoded from the next counter value so they line up with row/col.
  always_comb begin
    vbs_d    = (mode_d == MODE_PAL) ? VW'(VBLANK_START_PAL) : VW'(VBLANK_START_NTSC);
    hsync_d  = col_d < HW'(HSYNC_END);
    border_d = (col_d >= HW'(BORDER_START)) || (col_d < HW'(BORDER_END));
    hblank_d = hide_border ? border_d
             : ((col_d >= HW'(HBLANK_START)) || (col_d < HW'(HBLANK_END)));
    vsync_d  = row_d < VW'(VSYNC_END);
    vblank_d = (row_d >= vbs_d) || (row_d < VW'(VBLANK_END));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= MODE_NTSC;
      frame_cnt <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      hblank    <= 1'b1;
      vblank    <= 1'b1;
      border    <= 1'b1;
    end else begin
      col       <= col_d;
      row       <= row_d;
      mode_q    <= mode_d;
      frame_cnt <= fc_d;
      hsync     <= hsync_d;
      vsync     <= vsync_d;
      hblank    <= hblank_d;
      vblank    <= vblank_d;
      border    <= border_d;
    end
  end

  video_strobe_gen #(.HW(HW), .VW(VW), .COL(LRC_COL), .ROW(0), .USE_ROW(1'b0)) u_lrc (
    .clk(clk), .reset_n(reset_n), .adv(adv), .col_nxt(col_d), .row_nxt(row_d), .pulse(lrc));

  video_strobe_gen #(.HW(HW), .VW(VW), .COL(PRST_COL), .ROW(0), .USE_ROW(1'b0)) u_prst (
    .clk(clk), .reset_n(reset_n), .adv(adv), .col_nxt(col_d), .row_nxt(row_d), .pulse(prst));

  video_strobe_gen #(.HW(HW), .VW(VW), .COL(HBLANK_START), .ROW(0), .USE_ROW(1'b0)) u_hbs (
    .clk(clk), .reset_n(reset_n), .adv(adv), .col_nxt(col_d), .row_nxt(row_d), .pulse(hbs));

  video_strobe_gen #(.HW(HW), .VW(VW), .COL(VBE_COL), .ROW(VBLANK_END), .USE_ROW(1'b1)) u_vbe (
    .clk(clk), .reset_n(reset_n), .adv(adv), .col_nxt(col_d), .row_nxt(row_d), .pulse(vbe));

  // An advance onto 0/0 can only come from a frame wrap, since load never advances.
  video_strobe_gen #(.HW(HW), .VW(VW), .COL(0), .ROW(0), .USE_ROW(1'b1)) u_sof (
    .clk(clk), .reset_n(reset_n), .adv(adv), .col_nxt(col_d), .row_nxt(row_d), .pulse(sof));

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a behavioural raster model predicts every cycle.
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        reset_n, ce, mode_req, hide_border, load;
  logic [9:0]  load_row, load_col;
  logic [9:0]  row, col;
  logic        mode, hsync, vsync, hblank, vblank, border;
  logic        lrc, prst, vbe, hbs, sof;
  logic [15:0] frame_cnt;

  typedef struct packed {
    logic [9:0]  row;
    logic [9:0]  col;
    logic        mode;
    logic        hsync, vsync, hblank, vblank, border;
    logic        lrc, prst, vbe, hbs, sof;
    logic [15:0] fc;
  } obs_t;

  obs_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   m_row, m_col, m_mode, m_fc;
  int   lrc_cnt, hbs_cnt, sof_cnt;

  always #5 clk = ~clk;

  video_timing_gen dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .mode_req(mode_req), .hide_border(hide_border),
    .load(load), .load_row(load_row), .load_col(load_col),
    .row(row), .col(col), .mode(mode),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .border(border),
    .lrc(lrc), .prst(prst), .vbe(vbe), .hbs(hbs), .sof(sof), .frame_cnt(frame_cnt));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", tag, act, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o = {row, col, mode, hsync, vsync, hblank, vblank, border, lrc, prst, vbe, hbs, sof, frame_cnt};
    return o;
  endfunction

  function automatic obs_t expect_now(input logic l, input logic p, input logic v,
                                      input logic h, input logic s);
    obs_t e;
    e.row    = m_row[9:0];
    e.col    = m_col[9:0];
    e.mode   = m_mode[0];
    e.hsync  = m_col < 66;
    e.border = (m_col >= 413) || (m_col < 93);
    e.hblank = hide_border ? e.border : ((m_col >= 440) || (m_col < 68));
    e.vsync  = m_row < 3;
    e.vblank = (m_row >= (m_mode != 0 ? 308 : 258)) || (m_row < 16);
    e.lrc = l; e.prst = p; e.vbe = v; e.hbs = h; e.sof = s;
    e.fc     = m_fc[15:0];
    return e;
  endfunction

  // Drive one clk of stimulus, predict, then compare just after the edge.
  task automatic step(input logic c, input logic ld);
    int   vt;
    logic l, p, v, h, s;
    obs_t e;
    ce = c; load = ld;
    vt = (m_mode != 0) ? 313 : 263;
    {l, p, v, h, s} = '0;
    if (ld) begin
      m_col = (load_col >= 454) ? 0 : int'(load_col);
      m_row = (load_row >= vt) ? 0 : int'(load_row);
    end else if (c) begin
      if (m_col == 453) begin
        m_col = 0;
        if (m_row == vt - 1) begin
          m_row = 0; m_fc = (m_fc + 1) % 65536; m_mode = int'(mode_req); s = 1'b1;
        end else m_row++;
      end else m_col++;
      l = (m_col == 412); p = (m_col == 418); h = (m_col == 440);
      v = (m_row == 16) && (m_col == 12);
    end
    exp_q.push_back(expect_now(l, p, v, h, s));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("cycle", 64'(observe()), 64'(e));
    if (lrc) lrc_cnt++;
    if (hbs) hbs_cnt++;
    if (sof) sof_cnt++;
  endtask

  task automatic do_load(input int r, input int c, input logic with_ce);
    load_row = 10'(r); load_col = 10'(c);
    step(with_ce, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b0; mode_req = 1'b0; hide_border = 1'b0; load = 1'b0;
    load_row = '0; load_col = '0;
    m_row = 0; m_col = 0; m_mode = 0; m_fc = 0;
    lrc_cnt = 0; hbs_cnt = 0; sof_cnt = 0;
    #22;
    check("reset_vec", 64'(observe()), 64'(expect_now(0, 0, 0, 0, 0)));
    check("reset_hblank", 64'(hblank), 64'd1);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Continuous ce from reset: first advance, then a line wrap.
    step(1'b1, 1'b0);
    check("first_col", 64'(col), 64'd1);
    repeat (460) step(1'b1, 1'b0);
    check("wrap_row", 64'(row), 64'd1);
    check("wrap_col", 64'(col), 64'd7);

    // Jump to the end of the NTSC frame; load lands on the hbs column without a strobe.
    do_load(262, 440, 1'b1);
    check("ld_no_hbs", 64'(hbs), 64'd0);
    sof_cnt = 0;
    repeat (20) step(1'b1, 1'b0);
    check("ntsc_fc", 64'(frame_cnt), 64'd1);
    check("ntsc_sof", 64'(sof_cnt), 64'd1);
    check("ntsc_row", 64'(row), 64'd0);

    // PAL request mid-frame takes effect only at the next frame wrap.
    do_load(100, 0, 1'b0);
    mode_req = 1'b1;
    repeat (50) step(1'b1, 1'b0);
    check("mode_hold", 64'(mode), 64'd0);
    do_load(262, 450, 1'b0);
    repeat (10) step(1'b1, 1'b0);
    check("mode_pal", 64'(mode), 64'd1);
    do_load(262, 452, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    check("pal_row263", 64'(row), 64'd263);
    do_load(307, 450, 1'b0);
    repeat (8) step(1'b1, 1'b0);
    check("pal_vblank", 64'(vblank), 64'd1);
    do_load(312, 450, 1'b0);
    repeat (8) step(1'b1, 1'b0);
    check("pal_wrap_row", 64'(row), 64'd0);
    check("pal_fc", 64'(frame_cnt), 64'd3);

    // ce once every 4 clk over two lines.
    do_load(50, 0, 1'b0);
    lrc_cnt = 0; hbs_cnt = 0;
    repeat (908) begin
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
    end
    check("lrc_count", 64'(lrc_cnt), 64'd2);
    check("hbs_count", 64'(hbs_cnt), 64'd2);

    // Load priority and clamping.
    do_load(38, 255, 1'b1);
    check("ld_row", 64'(row), 64'd38);
    check("ld_col", 64'(col), 64'd255);
    do_load(38, 500, 1'b1);
    check("ld_col_clamp", 64'(col), 64'd0);
    do_load(38, 412, 1'b1);
    check("ld_no_lrc", 64'(lrc), 64'd0);
    do_load(400, 10, 1'b1);
    check("ld_row_clamp", 64'(row), 64'd0);

    // hide_border makes hblank follow border.
    hide_border = 1'b1;
    do_load(10, 79, 1'b0);
    step(1'b1, 1'b0);
    check("hide_c80", 64'(hblank), 64'd1);
    do_load(10, 92, 1'b0);
    step(1'b1, 1'b0);
    check("hide_c93", 64'(hblank), 64'd0);
    hide_border = 1'b0;

    // ce low holds everything.
    repeat (40) step(1'b0, 1'b0);
    check("hold_col", 64'(col), 64'd93);

    // Asynchronous reset mid-line.
    do_load(120, 300, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    m_row = 0; m_col = 0; m_mode = 0; m_fc = 0;
    #1;
    check("async_rst", 64'(observe()), 64'(expect_now(0, 0, 0, 0, 0)));
    #20;
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
